// File: rtl/stream_byte_packer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | stream_byte_packer: packs offset/size byte chunks into dense LE beats    |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module stream_byte_packer #(
  parameter int DATA_BYTES = 64,
  parameter int OFF_W      = $clog2(DATA_BYTES),
  parameter int CNT_W      = 32
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [OFF_W-1:0]        in_offset,
  input  logic [OFF_W:0]          in_size,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*DATA_BYTES-1:0] out_data,
  output logic [DATA_BYTES-1:0]   out_keep,
  output logic                    out_last,
  output logic [CNT_W-1:0]        frame_bytes,
  output logic                    flush_done,
  output logic                    err_overrun
);

  localparam int W  = 8 * DATA_BYTES;
  // Two spare bits so offset+size and fill+size never overflow.
  localparam int FW = OFF_W + 2;
  localparam logic [FW-1:0] DB_F = FW'(DATA_BYTES);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [FW-1:0]  fill;
  logic [FW-1:0]  fill_next;
  logic [FW-1:0]  base;
  logic           flushing;

  logic [FW-1:0]  off_ext;
  logic [FW-1:0]  size_ext;
  logic [FW-1:0]  end_pos;
  logic           clip;
  logic [FW-1:0]  eff_size;
  logic [W-1:0]   chunk;
  logic           in_fire;
  logic           out_fire;

  assign off_ext  = FW'(in_offset);
  assign size_ext = FW'(in_size);
  assign end_pos  = off_ext + size_ext;
  assign clip     = end_pos > DB_F;
  assign eff_size = clip ? (DB_F - off_ext) : size_ext;

  // Wanted bytes moved to byte 0, everything above eff_size masked off.
  assign chunk = (in_data >> {in_offset, 3'b000}) & ~({W{1'b1}} << {eff_size, 3'b000});

  assign in_ready  = resetn & ~flushing & ((fill < DB_F) | out_ready);
  assign out_valid = (fill >= DB_F) | (flushing & (fill != '0));
  assign out_data  = acc[W-1:0];
  assign out_last  = out_valid & flushing & (fill <= DB_F);
  assign out_keep  = out_valid ? ~({DATA_BYTES{1'b1}} << fill) : '0;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    acc_next = acc;
    base     = fill;
    if (out_fire) begin
      acc_next = acc >> W;
      base     = (fill > DB_F) ? (fill - DB_F) : '0;
    end
    fill_next = base;
    if (in_fire) begin
      acc_next  = acc_next | ({{W{1'b0}}, chunk} << {base, 3'b000});
      fill_next = base + eff_size;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc         <= '0;
      fill        <= '0;
      flushing    <= 1'b0;
      frame_bytes <= '0;
      flush_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      acc        <= acc_next;
      fill       <= fill_next;
      flush_done <= 1'b0;
      if (in_fire) begin
        frame_bytes <= frame_bytes + CNT_W'(eff_size);
        if (clip) err_overrun <= 1'b1;
        if (in_last) begin
          // An empty frame completes immediately without emitting a beat.
          if (fill_next == '0) begin
            flush_done  <= 1'b1;
            frame_bytes <= '0;
          end else begin
            flushing <= 1'b1;
          end
        end
      end
      if (out_fire && out_last) begin
        flushing    <= 1'b0;
        frame_bytes <= '0;
        flush_done  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_byte_packer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_stream_byte_packer: byte-queue reference model, random + directed     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_stream_byte_packer;

  localparam int DB = 64;
  localparam int W  = 8 * DB;
  localparam int OW = $clog2(DB);
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [OW-1:0] in_offset = '0;
  logic [OW:0]   in_size = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [DB-1:0] out_keep;
  logic          out_last;
  logic [CW-1:0] frame_bytes;
  logic          flush_done;
  logic          err_overrun;

  stream_byte_packer #(.DATA_BYTES(DB), .OFF_W(OW), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_offset(in_offset), .in_size(in_size), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .frame_bytes(frame_bytes),
    .flush_done(flush_done), .err_overrun(err_overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0]  data;
    logic [DB-1:0] keep;
    logic          last;
    int            n;
  } beat_t;

  // Model: bytes not yet formed into beats, and beats the DUT still owes.
  beat_t         exp_q[$];
  byte unsigned  pend[$];
  int            buffered = 0;
  logic [CW-1:0] m_frame = '0;
  logic          m_err = 1'b0;
  logic          m_done = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int stall = 0;
  int rdy_pct = 100;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic make_beat(input int n, input logic last);
    beat_t b;
    b.data = '0;
    b.keep = '0;
    b.last = last;
    b.n    = n;
    for (int i = 0; i < n; i++) begin
      b.data[8*i +: 8] = pend.pop_front();
      b.keep[i] = 1'b1;
    end
    exp_q.push_back(b);
  endtask

  task automatic set_ready();
    if (stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = ($urandom_range(99) < rdy_pct);
    end
  endtask

  // Called between negedge and posedge with inputs already driven.
  task automatic cycle(output logic fired);
    logic  closing, exp_rdy, out_fire;
    int    eff;
    beat_t b;
    #1;
    closing = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].last) closing = 1'b1;
    exp_rdy = !closing && (buffered < DB || out_ready);
    check("in_ready", W'(in_ready), W'(exp_rdy));
    check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
    if (out_valid && exp_q.size() > 0) begin
      check("out_data", out_data, exp_q[0].data);
      check("out_keep", W'(out_keep), W'(exp_q[0].keep));
      check("out_last", W'(out_last), W'(exp_q[0].last));
    end
    fired    = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    m_done   = 1'b0;
    if (out_fire && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      buffered -= b.n;
      if (b.last) begin
        m_done  = 1'b1;
        m_frame = '0;
      end
    end
    if (fired) begin
      if (int'(in_offset) + int'(in_size) > DB) begin
        eff   = DB - int'(in_offset);
        m_err = 1'b1;
      end else begin
        eff = int'(in_size);
      end
      for (int i = 0; i < eff; i++) pend.push_back(in_data[8*(int'(in_offset)+i) +: 8]);
      buffered += eff;
      m_frame  += CW'(eff);
      if (!in_last) begin
        while (pend.size() >= DB) make_beat(DB, 1'b0);
      end else begin
        while (pend.size() > DB) make_beat(DB, 1'b0);
        if (pend.size() > 0) make_beat(pend.size(), 1'b1);
        else if (buffered == 0) begin
          m_done  = 1'b1;
          m_frame = '0;
        end
      end
    end
    @(posedge clock);
    #1;
    check("flush_done", W'(flush_done), W'(m_done));
    check("frame_bytes", W'(frame_bytes), W'(m_frame));
    check("err_overrun", W'(err_overrun), W'(m_err));
  endtask

  task automatic send(input logic [W-1:0] d, input int off, input int sz, input logic last);
    logic fired;
    int   guard;
    fired = 1'b0;
    guard = 0;
    while (!fired) begin
      @(negedge clock);
      in_valid  = 1'b1;
      in_data   = d;
      in_offset = OW'(off);
      in_size   = (OW+1)'(sz);
      in_last   = last;
      set_ready();
      cycle(fired);
      guard++;
      if (!fired && guard > 200) begin
        check("send_timeout", W'(in_ready), W'(1));
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    logic fired;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 1'b0;
      set_ready();
      cycle(fired);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      idle(1);
      guard++;
    end
    check("drain_empty", W'(out_valid), W'(0));
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'(($urandom_range(1)));
    #1;
    check("rst_in_ready", W'(in_ready), W'(0));
    @(posedge clock);
    #1;
    exp_q.delete();
    pend.delete();
    buffered = 0;
    m_frame  = '0;
    m_err    = 1'b0;
    m_done   = 1'b0;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_keep", W'(out_keep), W'(0));
    check("rst_out_last", W'(out_last), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_frame_bytes", W'(frame_bytes), W'(0));
    check("rst_err", W'(err_overrun), W'(0));
    check("rst_flush_done", W'(flush_done), W'(0));
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    logic [W-1:0] w;
    int nchunks;

    do_reset();

    // Sixteen 8-byte chunks of incrementing bytes, then an empty closing chunk.
    rdy_pct = 100;
    for (int k = 0; k < 16; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(8*k + j);
      send(w, 0, 8, 1'b0);
    end
    send('0, 0, 0, 1'b1);
    drain();

    // 40 bytes from offset 10, then 40 bytes with in_last.
    send(rand_word(), 10, 40, 1'b0);
    send(rand_word(), 0, 40, 1'b1);
    drain();
    idle(2);

    // Output stalled for 10 cycles under full-width chunks.
    stall = 10;
    for (int k = 0; k < 3; k++) send(rand_word(), 0, 64, 1'b0);
    send(rand_word(), 0, 64, 1'b1);
    drain();

    // Overrun clipping; the flag must survive later frames.
    send(rand_word(), 60, 10, 1'b1);
    drain();
    send(rand_word(), 5, 20, 1'b1);
    drain();

    // Empty frame on an empty accumulator.
    send(rand_word(), 0, 0, 1'b1);
    idle(3);

    // Reset mid-frame with 30 buffered bytes.
    send(rand_word(), 0, 30, 1'b0);
    do_reset();
    send(rand_word(), 3, 17, 1'b1);
    drain();

    // Random frames with random backpressure.
    rdy_pct = 70;
    for (int f = 0; f < 40; f++) begin
      nchunks = $urandom_range(6, 1);
      if ($urandom_range(9) == 0) stall = $urandom_range(8, 1);
      for (int c = 0; c < nchunks; c++) begin
        send(rand_word(), $urandom_range(DB - 1), $urandom_range(DB),
             c == nchunks - 1);
        if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
      end
      if ($urandom_range(1) == 0) drain();
    end
    drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_byte_packer.md
# stream_byte_packer

- Parametrised successor to the fixed 512-bit packer.
- Gathers variable-length byte chunks (offset + size within a wide input word) into dense, little-endian output beats.
- Adds valid/ready backpressure on both sides, end-of-frame flush with a partial-beat byte mask, a per-frame byte counter and a sticky error flag.
- Sits between the relational cache row fetcher and the AXI write-back writer.

## Interface
- DATA_BYTES, 64: bytes per input word and per output beat; power of two, 4..128.
- OFF_W, $clog2(DATA_BYTES): offset width.
- CNT_W, 32: width of the frame byte counter.
- clock  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  chunk present.
- in_ready  out  1  chunk accepted when in_valid & in_ready.
- in_data  in  8*DATA_BYTES  source word; byte k = in_data[8k+7:8k].
- in_offset  in  OFF_W  first wanted byte index.
- in_size  in  OFF_W+1  wanted byte count, 0..DATA_BYTES.
- in_last  in  1  chunk ends the frame.
- out_valid  out  1  beat present.
- out_ready  in  1  beat consumed when out_valid & out_ready.
- out_data  out  8*DATA_BYTES  packed beat.
- out_keep  out  DATA_BYTES  byte-valid mask.
- out_last  out  1  final beat of frame.
- frame_bytes  out  CNT_W  bytes accepted in current frame.
- flush_done  out  1  one-cycle pulse when a frame completes.
- err_overrun  out  1  sticky: a chunk had in_offset+in_size > DATA_BYTES.

## Operation
- Storage: 2*DATA_BYTES-byte accumulator `acc`, fill counter `fill` (0..2*DATA_BYTES-1), flag `flushing`.
- Accept: bytes in_data[offset .. offset+size-1] are appended at acc[fill..]; fill += size.
- Clipping: if offset+size > DATA_BYTES, effective size = DATA_BYTES-offset; err_overrun set and held until reset.
- in_ready = resetn & !flushing & (fill < DATA_BYTES | out_ready). The combinational path out_ready -> in_ready is intentional.
- out_valid = fill >= DATA_BYTES | (flushing & fill > 0). out_data = acc[0..DATA_BYTES-1].
- Non-flush beats: out_keep all ones, out_last 0.
- Flush beat (flushing & fill <= DATA_BYTES): out_last 1; out_keep = low `fill` bits set; bytes at or above fill read as zero.
- Output fire: acc shifts down DATA_BYTES bytes (zero fill); fill -= DATA_BYTES, saturating at 0 for the flush beat.
- Simultaneous input and output fire: shift first, then append at fill-DATA_BYTES. Net fill = fill-DATA_BYTES+size.
- in_last accepted: flushing=1 and input is blocked. When the out_last beat fires:
  - flushing=0, fill=0, frame_bytes=0, flush_done=1 for the next cycle.
- in_last accepted with zero resulting fill (empty frame): no beat is emitted; flush_done pulses next cycle; frame_bytes cleared.
- frame_bytes += effective size on each accept; wraps modulo 2^CNT_W.

## Timing
- Reset (resetn low at an edge): fill=0, flushing=0, acc=0, frame_bytes=0, err_overrun=0, flush_done=0. Hence out_valid=0, out_keep=0, out_last=0, out_data=0. in_ready is held 0 while resetn is low.
- Reset mid-frame discards all buffered bytes; no beat is emitted.
- Latency: a chunk accepted in cycle N that brings fill to >= DATA_BYTES gives out_valid in cycle N+1.
- Throughput: one input chunk and one output beat per cycle, sustained.
- out_data, out_keep and out_last are stable while out_valid & !out_ready.
- in_data and out_data are never combinationally connected.

## Test plan
- DATA_BYTES=64: sixteen chunks, offset 0, size 8, bytes 0..127 incrementing -> out_data bytes 0..63 in cycle after chunk 8, then 64..127; both beats keep=all ones.
- Chunk size 40 offset 10, then size 40 offset 0 with in_last, out_ready=1:
  - beat 1 = src bytes 10..49 then 24 bytes of chunk 2, keep all ones, last 0.
  - beat 2 = remaining 16 bytes, keep=0xFFFF, last 1.
  - flush_done pulses one cycle later; frame_bytes returns to 0.
- out_ready held 0 for 10 cycles while chunks of size 64 arrive:
  - in_ready drops once fill >= 64.
  - out_data is stable throughout.
  - on release, beats drain one per cycle with no byte loss.
- offset 60, size 10 -> 4 bytes appended, err_overrun=1 and held across later frames until reset.
- in_size 0 with in_last on an empty accumulator -> no out_valid; flush_done pulses once.
- resetn low for one cycle with fill=30 mid-frame -> all outputs 0; next frame's first byte lands at out_data[7:0].
